// File: rtl/irq_gateway.sv
// rtl/irq_gateway.sv - per-source interrupt gateway feeding the PLIC request inputs
module irq_gateway #(
    parameter int NSRC        = 31,
    parameter int SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [23:0]     i_addr,
    input  logic [3:0]      i_we,
    input  logic [31:0]     i_dat_w,
    output logic [31:0]     o_dat_r,
    input  logic            i_stb,
    output logic            o_ack,
    input  logic [NSRC-1:0] i_irq,
    input  logic            i_cmpl_stb,
    input  logic [4:0]      i_cmpl_id,
    output logic [NSRC-1:0] o_int
);
    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam logic [23:0] A_MODE     = 24'h000000;
    localparam logic [23:0] A_MASK     = 24'h000004;
    localparam logic [23:0] A_INFLIGHT = 24'h000008;
    localparam logic [23:0] A_LEVEL    = 24'h00000C;

    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] dly_q;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] dfr_q, dfr_d;
    logic [NSRC-1:0] int_q, int_d;
    state_t          st_q [NSRC];
    state_t          st_d [NSRC];

    logic [NSRC-1:0] level, rise, inflight;
    logic [31:0]     be_mask;
    logic            unused_bits;

    assign level       = sync_q[SYNC_STAGES-1];
    assign rise        = level & ~dly_q;
    assign be_mask     = {{8{i_we[3]}}, {8{i_we[2]}}, {8{i_we[1]}}, {8{i_we[0]}}};
    assign unused_bits = ^{be_mask, i_dat_w};
    assign o_ack       = i_stb;
    assign o_int       = int_q;

    // Input synchroniser chain plus one-cycle delayed copy for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            dly_q <= '0;
        end else begin
            sync_q[0] <= i_irq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            dly_q <= level;
        end
    end

    // Byte-enabled writes to MODE and MASK; bit 0 of the bus word is never stored
    always_comb begin
        mode_d = mode_q;
        mask_d = mask_q;
        if (i_stb && i_addr == A_MODE)
            mode_d = (mode_q & ~be_mask[NSRC:1]) | (i_dat_w[NSRC:1] & be_mask[NSRC:1]);
        if (i_stb && i_addr == A_MASK)
            mask_d = (mask_q & ~be_mask[NSRC:1]) | (i_dat_w[NSRC:1] & be_mask[NSRC:1]);
    end

    // Per-source IDLE/WAIT next state, request pulse and deferred-edge flag
    always_comb begin
        dfr_d = dfr_q;
        int_d = '0;
        for (int k = 0; k < NSRC; k++) begin
            st_d[k] = st_q[k];
            case (st_q[k])
                ST_IDLE: begin
                    if (mask_q[k] && (mode_q[k] ? (rise[k] || dfr_q[k]) : level[k])) begin
                        st_d[k]  = ST_WAIT;
                        int_d[k] = 1'b1;
                        dfr_d[k] = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mode_q[k] && rise[k])
                        dfr_d[k] = 1'b1;
                    if (i_cmpl_stb && i_cmpl_id == 5'(k + 1))
                        st_d[k] = ST_IDLE;
                end
                default: st_d[k] = ST_IDLE;
            endcase
        end
        // switching a source to level mode drops any edge it was holding
        dfr_d = dfr_d & mode_d;
    end

    // State, configuration and request-pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NSRC; k++) st_q[k] <= ST_IDLE;
            mode_q <= '0;
            mask_q <= '1;
            dfr_q  <= '0;
            int_q  <= '0;
        end else begin
            for (int k = 0; k < NSRC; k++) st_q[k] <= st_d[k];
            mode_q <= mode_d;
            mask_q <= mask_d;
            dfr_q  <= dfr_d;
            int_q  <= int_d;
        end
    end

    // Which sources are currently blocked awaiting completion
    always_comb begin
        inflight = '0;
        for (int k = 0; k < NSRC; k++) inflight[k] = (st_q[k] == ST_WAIT);
    end

    // Combinational register read mux; source k appears on bit k
    always_comb begin
        o_dat_r = '0;
        case (i_addr)
            A_MODE:     o_dat_r[NSRC:1] = mode_q;
            A_MASK:     o_dat_r[NSRC:1] = mask_q;
            A_INFLIGHT: o_dat_r[NSRC:1] = inflight;
            A_LEVEL:    o_dat_r[NSRC:1] = level;
            default:    o_dat_r = '0;
        endcase
    end
endmodule

// File: tb/tb_irq_gateway.sv
// tb/tb_irq_gateway.sv - self-checking bench for irq_gateway
module tb_irq_gateway;
    localparam int N = 31;
    localparam int S = 2;
    localparam logic [31:0] SRC_BITS = 32'hFFFF_FFFE;

    logic          clk = 1'b0;
    logic          rst;
    logic [23:0]   addr;
    logic [3:0]    we;
    logic [31:0]   dat_w;
    logic [31:0]   dat_r;
    logic          stb;
    logic          ack;
    logic [N-1:0]  irq;
    logic          cmpl_stb;
    logic [4:0]    cmpl_id;
    logic [N-1:0]  oint;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    irq_gateway #(.NSRC(N), .SYNC_STAGES(S)) dut (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_we(we), .i_dat_w(dat_w),
        .o_dat_r(dat_r), .i_stb(stb), .o_ack(ack), .i_irq(irq),
        .i_cmpl_stb(cmpl_stb), .i_cmpl_id(cmpl_id), .o_int(oint)
    );

    always #5 clk = ~clk;

    // Reference model: 32-bit register images, bit k = source k
    logic [31:0] m_mode, m_mask, m_wait, m_pend, m_lvl, m_prev, m_int;
    logic [31:0] m_past [S];

    always @(posedge clk) begin : mdl
        logic [31:0] rise, nint, bem;
        logic trig;
        if (rst) begin
            m_mode = 0; m_mask = SRC_BITS; m_wait = 0; m_pend = 0;
            m_lvl = 0; m_prev = 0; m_int = 0;
            for (int s = 0; s < S; s++) m_past[s] = 0;
            chk_en = 1'b1;
        end else begin
            rise = m_lvl & ~m_prev;
            nint = 0;
            for (int k = 1; k <= N; k++) begin
                if (!m_wait[k]) begin
                    trig = m_mode[k] ? (rise[k] | m_pend[k]) : m_lvl[k];
                    if (m_mask[k] && trig) begin
                        m_wait[k] = 1'b1; nint[k] = 1'b1; m_pend[k] = 1'b0;
                    end
                end else begin
                    if (m_mode[k] && rise[k]) m_pend[k] = 1'b1;
                    if (cmpl_stb && int'(cmpl_id) == k) m_wait[k] = 1'b0;
                end
            end
            m_int = nint;
            bem = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
            if (stb && addr == 24'h0) m_mode = ((m_mode & ~bem) | (dat_w & bem)) & SRC_BITS;
            if (stb && addr == 24'h4) m_mask = ((m_mask & ~bem) | (dat_w & bem)) & SRC_BITS;
            m_pend = m_pend & m_mode;
            m_prev = m_lvl;
            for (int s = S - 1; s > 0; s--) m_past[s] = m_past[s-1];
            m_past[0] = {irq, 1'b0};
            m_lvl = m_past[S-1];
        end
    end

    function automatic logic [31:0] exp_read(input logic [23:0] a);
        case (a)
            24'h0:   return m_mode;
            24'h4:   return m_mask;
            24'h8:   return m_wait;
            24'hC:   return m_lvl;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_int", {oint, 1'b0}, m_int);
            chk("o_dat_r", dat_r, exp_read(addr));
            chk("o_ack", {31'b0, ack}, {31'b0, stb});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] w);
        addr = a; dat_w = d; we = w; stb = 1'b1;
        tick();
        stb = 1'b0; we = 4'h0;
    endtask

    task automatic rd(input logic [23:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        chk(name, dat_r, exp);
    endtask

    task automatic cmpl(input int id);
        cmpl_stb = 1'b1; cmpl_id = 5'(id);
        tick();
        cmpl_stb = 1'b0; cmpl_id = 5'd0;
    endtask

    task automatic count_pulses(input int b, input int n, output int c);
        c = 0;
        repeat (n) begin
            tick();
            #1;
            if (oint[b]) c++;
        end
    endtask

    int c;

    initial begin
        rst = 1'b1; addr = 0; we = 0; dat_w = 0; stb = 0;
        irq = '0; cmpl_stb = 0; cmpl_id = 0;
        repeat (3) tick();
        rd(24'h4, 32'hFFFF_FFFE, "mask_reset");
        rd(24'h0, 32'h0, "mode_reset");
        chk("oint_reset", {1'b0, oint}, 32'h0);

        // level source 3: pulse in cycle 3 only, re-request 2 cycles after completion
        rst = 1'b0; irq[2] = 1'b1; cyc = 0;
        tick(); #1 chk("lvl_c1", {1'b0, oint}, 32'h0);
        tick(); #1 chk("lvl_c2", {1'b0, oint}, 32'h0);
        tick(); #1 chk("lvl_c3", {1'b0, oint}, 32'h4);
        tick(); #1 chk("lvl_c4", {1'b0, oint}, 32'h0);
        rd(24'h8, 32'h8, "lvl_inflight");
        while (cyc < 10) tick();
        cmpl_stb = 1'b1; cmpl_id = 5'd3;
        tick(); cmpl_stb = 1'b0; cmpl_id = 0;
        #1 chk("lvl_c11", {1'b0, oint}, 32'h0);
        tick(); #1 chk("lvl_c12", {1'b0, oint}, 32'h4);
        irq[2] = 1'b0;
        repeat (4) tick();
        cmpl(3);
        count_pulses(2, 6, c);
        chk("lvl_dropped_no_rereq", c, 0);
        rd(24'h8, 32'h0, "lvl_idle");

        // edge source 5: many edges in WAIT collapse into one re-request
        wr(24'h0, 32'h20, 4'hF);
        irq[4] = 1'b1;
        count_pulses(4, 6, c);
        chk("edge_first", c, 1);
        repeat (3) begin
            irq[4] = 1'b0; tick(); tick();
            irq[4] = 1'b1; tick(); tick();
        end
        tick(); tick();
        cmpl(5);
        count_pulses(4, 6, c);
        chk("edge_one_rereq", c, 1);
        cmpl(5);
        count_pulses(4, 6, c);
        chk("edge_no_rereq", c, 0);

        // same-cycle edge and completion
        irq[4] = 1'b0; repeat (3) tick();
        irq[4] = 1'b1;
        count_pulses(4, 5, c);
        chk("edge_reissue", c, 1);
        irq[4] = 1'b0; repeat (3) tick();
        irq[4] = 1'b1;
        tick(); tick();
        cmpl_stb = 1'b1; cmpl_id = 5'd5;
        tick(); cmpl_stb = 1'b0; cmpl_id = 0;
        #1 chk("same_cyc_c3", {1'b0, oint}, 32'h0);
        tick(); #1 chk("same_cyc_c4", {1'b0, oint}, 32'h10);
        cmpl(0);
        cmpl(7);
        rd(24'h8, 32'h20, "bad_id_ignored");
        cmpl(5);

        // mask gates new issue only
        irq[4] = 1'b0; repeat (3) tick();
        wr(24'h4, 32'hFFFF_FFFD, 4'hF);
        wr(24'h0, 32'h0, 4'hF);
        irq[0] = 1'b1;
        repeat (5) tick();
        rd(24'h8, 32'h0, "masked_inflight");
        addr = 24'hC; #1 chk("masked_level", dat_r & 32'h2, 32'h2);
        wr(24'h4, 32'hFFFF_FFFF, 4'hF);
        count_pulses(0, 2, c);
        chk("unmask_pulse", c, 1);
        rd(24'h4, 32'hFFFF_FFFE, "mask_bit0");

        // byte enables and read-only registers
        wr(24'h0, 32'h1234_5678, 4'b0010);
        rd(24'h0, 32'h0000_5600, "mode_be");
        wr(24'h8, 32'hFFFF_FFFF, 4'hF);
        rd(24'h8, 32'h2, "inflight_ro");
        wr(24'h10, 32'hFFFF_FFFF, 4'hF);
        rd(24'h10, 32'h0, "unmapped");

        // reset while sources 2 and 4 wait with deferred edges
        irq[0] = 1'b0; repeat (3) tick();
        cmpl(1);
        wr(24'h0, 32'h14, 4'hF);
        irq[1] = 1'b1; irq[3] = 1'b1;
        repeat (4) tick();
        irq[1] = 1'b0; irq[3] = 1'b0; tick(); tick();
        irq[1] = 1'b1; irq[3] = 1'b1; repeat (3) tick();
        rd(24'h8, 32'h14, "pre_rst_inflight");
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        rd(24'h8, 32'h0, "rst_inflight");
        rd(24'h0, 32'h0, "rst_mode");
        rd(24'h4, 32'hFFFF_FFFE, "rst_mask");
        tick(); #1 chk("rst_c1", {1'b0, oint}, 32'h0);
        tick(); #1 chk("rst_c2", {1'b0, oint}, 32'h0);
        tick(); #1 chk("rst_c3", {1'b0, oint}, 32'hA);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 15) == 0) irq[b] = ~irq[b];
            cmpl_stb = ($urandom_range(0, 1) == 0);
            cmpl_id  = 5'($urandom_range(0, 31));
            r = $urandom_range(0, 19);
            dat_w = $urandom;
            we    = 4'($urandom_range(0, 15));
            if (r == 0)      begin addr = 24'h0; stb = 1'b1; end
            else if (r == 1) begin addr = 24'h4; stb = 1'b1; end
            else if (r == 2) begin addr = 24'(4 * $urandom_range(2, 4)); stb = 1'b1; end
            else begin
                addr = 24'(4 * $urandom_range(0, 5));
                stb  = ($urandom_range(0, 1) == 0);
                we   = 4'h0;
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0; stb = 1'b0; we = 0; cmpl_stb = 0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
